flash_ctrl: RTL and testbench
=============================

// Module: flash_ctrl
// PURPOSE
//  Initiator side of the flash macro interface: drives cs_n/we_n/oe_n/addr/wdata into flash_wrapper.
//  Takes single 32-bit read/write requests from the SoC bus over a valid/ready request channel.
//  Sequences setup, strobe, wait-for-ready and recovery timing for each access.
//  Returns read data and an error flag on a valid/ready response channel.
// PARAMETERS
//  ADDR_W       24   flash word address width
//  DATA_W       32   data width
//  SETUP_CYC    1    cycles cs_n low with addr/wdata stable before the oe_n/we_n strobe (>=1)
//  WR_CYC       4    we_n low pulse length in cycles; writes complete on time, flash_ready is not used (>=1)
//  RECOVER_CYC  2    cycles all strobes high after an access (>=1; flash_ready lags cs_n by 1 cycle)
//  TIMEOUT      256  RD_WAIT cycles without flash_ready before the read aborts with an error
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       request valid
//  req_ready    out  1       request accepted when valid&ready; high only in IDLE
//  req_we       in   1       1=write, 0=read
//  req_addr     in   ADDR_W  word address
//  req_wdata    in   DATA_W  write data
//  rsp_valid    out  1       response valid; held until rsp_ready
//  rsp_ready    in   1       response accepted
//  rsp_rdata    out  DATA_W  read data (0 for writes and timeouts)
//  rsp_err      out  1       1 = read timed out
//  busy         out  1       state != IDLE
//  flash_cs_n   out  1       chip select, active low
//  flash_we_n   out  1       write strobe, active low
//  flash_oe_n   out  1       output enable, active low
//  flash_addr   out  ADDR_W  address to the flash
//  flash_wdata  out  DATA_W  write data to the flash
//  flash_rdata  in   DATA_W  read data from the flash
//  flash_ready  in   1       registered ready from the flash (rises 1 cycle after cs_n and oe_n are both low)
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async, immediate): state=IDLE; cs_n/we_n/oe_n=1; flash_addr, flash_wdata, rsp_rdata=0;
//    rsp_valid, rsp_err, busy=0; req_ready=1 after reset is released.
//  - FSM states: IDLE, SETUP, RD_WAIT, WR_PULSE, RECOVER, RESP. One down-counter is reloaded on each
//    state entry.
//  - IDLE: on req_valid & req_ready, latch addr/wdata/we onto flash_addr/flash_wdata, drive cs_n=0,
//    go to SETUP.
//  - SETUP: hold for SETUP_CYC cycles. On exit, a read drives oe_n=0 and enters RD_WAIT;
//    a write drives we_n=0 and enters WR_PULSE.
//  - RD_WAIT: sample flash_ready each edge.
//    - ready=1: capture flash_rdata into rsp_rdata, rsp_err=0, cs_n/oe_n=1, go to RECOVER.
//    - TIMEOUT cycles elapsed with no ready: rsp_rdata=0, rsp_err=1, strobes high, go to RECOVER.
//  - WR_PULSE: hold we_n low for WR_CYC cycles, then cs_n/we_n=1, go to RECOVER.
//  - RECOVER: all strobes high for RECOVER_CYC cycles, then rsp_valid=1 and go to RESP.
//    This guarantees a stale flash_ready is never sampled by the next access.
//  - RESP: hold rsp_valid/rsp_rdata/rsp_err stable until rsp_ready. Then clear rsp_valid and go to IDLE.
//    A new request is accepted no earlier than the cycle after that.
//  - Latency with defaults and a zero-wait flash, counted in edges after the accepting edge:
//    - read: rsp_valid is high after SETUP_CYC+2+RECOVER_CYC = 5 edges;
//    - write: rsp_valid is high after SETUP_CYC+WR_CYC+RECOVER_CYC = 7 edges.
//  - Invariants: we_n and oe_n are never low at the same time; neither is low while cs_n is high.
//  - flash_addr/flash_wdata stay stable from accept until RESP exits.
//  - flash_ready is ignored in every state other than RD_WAIT.
//  - Reset asserted mid-access: strobes go high asynchronously and the access is dropped with no
//    response. The bus master must reissue the request.
//  - Parameter checks (elaboration-time $error): SETUP_CYC, WR_CYC, RECOVER_CYC and TIMEOUT must each be >=1.
// STRUCTURE
//  - flash_pkg:
//    - typedef enum logic [2:0] flash_state_e (the six FSM states);
//    - localparams FLASH_ADDR_W=24 and FLASH_DATA_W=32;
//    - default timing constants.
//  - Sub-module flash_timer: loadable down-counter (load value, load strobe, zero flag).
//    Width is $clog2 of the largest of the timing parameters.
//  - flash_ctrl holds the FSM, the request/response registers and the strobe registers.
// TESTING
//  - Read 0x000123, flash model returns 0xDEADBEEF with ready 1 cycle after oe_n ->
//    rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 5 edges after accept, no overlap of we_n and oe_n.
//  - Write 0xFFFFFF / 0xA5A5A5A5 -> flash_we_n low exactly 4 cycles with cs_n low;
//    rsp_valid 7 edges after accept, rsp_rdata=0.
//  - Flash model never raises ready -> after 256 RD_WAIT cycles rsp_err=1, rsp_rdata=0; strobes return high.
//  - rsp_ready held low for 10 cycles -> response held stable; req_ready=0; a second request is not accepted
//    until the cycle after the rsp handshake.
//  - Back-to-back read, write, read with flash_ready left high from the prior read ->
//    the second read waits for a fresh ready and returns correct data.
//  - rst_n pulsed low during WR_PULSE -> cs_n/we_n high in the same cycle; no rsp_valid;
//    the next request completes normally.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared types and constants for the flash macro initiator: state encoding,
// bus widths, default access timing and the timer width helper.
package flash_pkg;

  localparam int FLASH_ADDR_W = 24;
  localparam int FLASH_DATA_W = 32;

  localparam int DEF_SETUP_CYC   = 1;
  localparam int DEF_WR_CYC      = 4;
  localparam int DEF_RECOVER_CYC = 2;
  localparam int DEF_TIMEOUT     = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RD_WAIT,
    ST_WR_PULSE,
    ST_RECOVER,
    ST_RESP
  } flash_state_e;

  // The timer is loaded with (cycles - 1), so $clog2 of the largest count is enough.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/flash_ctrl_if.sv
// SoC-side request/response channels of the flash controller.
// master = SoC bus initiator, slave = flash_ctrl.
interface flash_ctrl_if
  import flash_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int DATA_W = FLASH_DATA_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/flash_timer.sv
// Loadable down-counter that paces every FSM state; stops at zero and flags it.
module flash_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/flash_ctrl.sv
// Flash macro initiator: accepts single read/write requests, sequences the
// setup/strobe/wait/recovery timing on the flash pins and returns a response.
module flash_ctrl
  import flash_pkg::*;
#(
  parameter int ADDR_W      = FLASH_ADDR_W,
  parameter int DATA_W      = FLASH_DATA_W,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int WR_CYC      = DEF_WR_CYC,
  parameter int RECOVER_CYC = DEF_RECOVER_CYC,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  flash_ctrl_if.slave       bus,
  output logic              busy,
  output logic              flash_cs_n,
  output logic              flash_we_n,
  output logic              flash_oe_n,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_wdata,
  input  logic [DATA_W-1:0] flash_rdata,
  input  logic              flash_ready
);

  if (SETUP_CYC < 1)   begin : g_chk_setup   $error("SETUP_CYC must be >= 1");   end
  if (WR_CYC < 1)      begin : g_chk_wr      $error("WR_CYC must be >= 1");      end
  if (RECOVER_CYC < 1) begin : g_chk_recover $error("RECOVER_CYC must be >= 1"); end
  if (TIMEOUT < 1)     begin : g_chk_timeout $error("TIMEOUT must be >= 1");     end

  localparam int TMR_W = timer_width(SETUP_CYC, WR_CYC, RECOVER_CYC, TIMEOUT);
  localparam logic [TMR_W-1:0] LD_SETUP   = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] LD_WR      = TMR_W'(WR_CYC - 1);
  localparam logic [TMR_W-1:0] LD_RECOVER = TMR_W'(RECOVER_CYC - 1);
  localparam logic [TMR_W-1:0] LD_TIMEOUT = TMR_W'(TIMEOUT - 1);

  flash_state_e      r_state, w_state_nx;
  logic              r_we, w_we_nx;
  logic              r_cs_n, w_cs_n_nx;
  logic              r_we_n, w_we_n_nx;
  logic              r_oe_n, w_oe_n_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_wdata, w_wdata_nx;
  logic [DATA_W-1:0] r_rdata, w_rdata_nx;
  logic              r_err, w_err_nx;
  logic              r_rsp_valid, w_rsp_valid_nx;
  logic              r_req_ready, r_busy;
  logic              w_tmr_load, w_tmr_zero;
  logic [TMR_W-1:0]  w_tmr_val;

  flash_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nx     = r_state;
    w_we_nx        = r_we;
    w_cs_n_nx      = r_cs_n;
    w_we_n_nx      = r_we_n;
    w_oe_n_nx      = r_oe_n;
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
    w_rdata_nx     = r_rdata;
    w_err_nx       = r_err;
    w_rsp_valid_nx = r_rsp_valid;
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_we_nx    = bus.req_we;
          w_addr_nx  = bus.req_addr;
          w_wdata_nx = bus.req_wdata;
          w_rdata_nx = '0;
          w_err_nx   = 1'b0;
          w_cs_n_nx  = 1'b0;
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_SETUP;
          w_state_nx = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          if (r_we) begin
            w_we_n_nx  = 1'b0;
            w_tmr_val  = LD_WR;
            w_state_nx = ST_WR_PULSE;
          end else begin
            w_oe_n_nx  = 1'b0;
            w_tmr_val  = LD_TIMEOUT;
            w_state_nx = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        // A ready on the last timeout cycle still wins over the timeout.
        if (flash_ready || w_tmr_zero) begin
          w_rdata_nx = flash_ready ? flash_rdata : '0;
          w_err_nx   = !flash_ready;
          w_cs_n_nx  = 1'b1;
          w_oe_n_nx  = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_RECOVER;
          w_state_nx = ST_RECOVER;
        end
      end
      ST_WR_PULSE: begin
        if (w_tmr_zero) begin
          w_cs_n_nx  = 1'b1;
          w_we_n_nx  = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_RECOVER;
          w_state_nx = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (w_tmr_zero) begin
          w_rsp_valid_nx = 1'b1;
          w_state_nx     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nx = 1'b0;
          w_state_nx     = ST_IDLE;
        end
      end
      default: begin
        w_cs_n_nx  = 1'b1;
        w_we_n_nx  = 1'b1;
        w_oe_n_nx  = 1'b1;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_cs_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_we        <= w_we_nx;
      r_cs_n      <= w_cs_n_nx;
      r_we_n      <= w_we_n_nx;
      r_oe_n      <= w_oe_n_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
      r_rdata     <= w_rdata_nx;
      r_err       <= w_err_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_req_ready <= (w_state_nx == ST_IDLE);
      r_busy      <= (w_state_nx != ST_IDLE);
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign busy          = r_busy;
  assign flash_cs_n    = r_cs_n;
  assign flash_we_n    = r_we_n;
  assign flash_oe_n    = r_oe_n;
  assign flash_addr    = r_addr;
  assign flash_wdata   = r_wdata;

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: a behavioural flash device with
// configurable ready latency, plus a reference memory predicting read data.
module tb_flash_ctrl;
  import flash_pkg::*;

  localparam int SETUP   = DEF_SETUP_CYC;
  localparam int WRC     = DEF_WR_CYC;
  localparam int REC     = DEF_RECOVER_CYC;
  localparam int TMO     = DEF_TIMEOUT;
  localparam int WR_LAT  = SETUP + WRC + REC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy, flash_cs_n, flash_we_n, flash_oe_n;
  logic [23:0] flash_addr;
  logic [31:0] flash_wdata;
  logic [31:0] flash_rdata = '0;
  logic        flash_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flash_ctrl_if bus ();

  flash_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .flash_cs_n  (flash_cs_n),
    .flash_we_n  (flash_we_n),
    .flash_oe_n  (flash_oe_n),
    .flash_addr  (flash_addr),
    .flash_wdata (flash_wdata),
    .flash_rdata (flash_rdata),
    .flash_ready (flash_ready)
  );

  // Flash device: ready rises model_lat+1 edges after cs_n/oe_n both go low,
  // and lingers model_hold edges after the strobes release.
  logic [31:0] fmem    [logic [23:0]];
  logic [31:0] ref_mem [logic [23:0]];
  int model_lat  = 0;
  int model_hold = 0;
  bit model_en   = 1'b1;
  int low_cnt    = 0;
  int hold_cnt   = 0;

  function automatic logic [31:0] pattern(input logic [23:0] a);
    return {8'hC3, a};
  endfunction

  function automatic logic [31:0] flash_read(input logic [23:0] a);
    return fmem.exists(a) ? fmem[a] : pattern(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  always @(posedge clk) begin
    if (!flash_cs_n && !flash_we_n) fmem[flash_addr] = flash_wdata;
    flash_rdata <= flash_read(flash_addr);
    if (!flash_cs_n && !flash_oe_n) begin
      if (low_cnt >= model_lat && model_en) flash_ready <= 1'b1;
      low_cnt++;
      hold_cnt = model_hold;
    end else begin
      low_cnt = 0;
      if (hold_cnt > 0) hold_cnt--;
      else flash_ready <= 1'b0;
    end
  end

  // Pin-level protocol watcher: counts strobe violations, measures we_n pulses.
  int viol_cnt      = 0;
  int we_low_run    = 0;
  int last_we_width = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      we_low_run = 0;
    end else begin
      if ((!flash_we_n && !flash_oe_n) || ((!flash_we_n || !flash_oe_n) && flash_cs_n)) begin
        viol_cnt++;
        $display("strobe violation at %0t: cs_n=%b we_n=%b oe_n=%b",
                 $time, flash_cs_n, flash_we_n, flash_oe_n);
      end
      if (!flash_we_n) we_low_run++;
      else begin
        if (we_low_run > 0) last_we_width = we_low_run;
        we_low_run = 0;
      end
    end
  end

  task automatic do_access(input bit we, input logic [23:0] addr, input logic [31:0] wdata,
                           input int rsp_delay, input int exp_lat,
                           input logic [31:0] exp_rdata, input bit exp_err, input string name);
    int lat = 0;
    bit got = 1'b0;
    bit addr_bad = 1'b0;
    bit hold_bad = 1'b0;
    int viol0 = viol_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int i = 0; i < 50 && !got; i++) begin
      if (bus.req_ready) got = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s accept: req_ready never seen within 50 cycles", name);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 400 && !got; k++) begin
      if (flash_addr !== addr || (we && flash_wdata !== wdata)) addr_bad = 1'b1;
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s response: rsp_valid not seen within 400 cycles", name);
      return;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if ({bus.rsp_rdata, bus.rsp_err} !== {exp_rdata, exp_err}) begin
      n_fail++;
      $display("FAIL %s response data: got %h err=%b, expected %h err=%b",
               name, bus.rsp_rdata, bus.rsp_err, exp_rdata, exp_err);
    end
    n_checks++;
    if ({flash_cs_n, flash_we_n, flash_oe_n, busy, bus.req_ready} !== 5'b11110) begin
      n_fail++;
      $display("FAIL %s resp state: cs/we/oe/busy/req_ready=%b, expected 11110", name,
               {flash_cs_n, flash_we_n, flash_oe_n, busy, bus.req_ready});
    end
    for (int i = 0; i < rsp_delay; i++) begin
      @(posedge clk); #1;
      if (!bus.rsp_valid || bus.rsp_rdata !== exp_rdata || bus.rsp_err !== exp_err
          || bus.req_ready) hold_bad = 1'b1;
      if (flash_addr !== addr) addr_bad = 1'b1;
    end
    n_checks++;
    if (hold_bad) begin
      n_fail++;
      $display("FAIL %s hold: response changed while rsp_ready low for %0d cycles",
               name, rsp_delay);
    end
    n_checks++;
    if (addr_bad) begin
      n_fail++;
      $display("FAIL %s addr/wdata: flash_addr/wdata not stable, last %h/%h expected %h/%h",
               name, flash_addr, flash_wdata, addr, wdata);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL %s release: rsp_valid/req_ready/busy=%b, expected 010", name,
               {bus.rsp_valid, bus.req_ready, busy});
    end
    n_checks++;
    if (viol_cnt !== viol0) begin
      n_fail++;
      $display("FAIL %s strobes: %0d strobe overlap violations, expected 0", name,
               viol_cnt - viol0);
    end
    if (we) begin
      n_checks++;
      if (last_we_width !== WRC || flash_read(addr) !== wdata) begin
        n_fail++;
        $display("FAIL %s write: we_n width %0d (expected %0d), flash holds %h (expected %h)",
                 name, last_we_width, WRC, flash_read(addr), wdata);
      end
      ref_mem[addr] = wdata;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({flash_cs_n, flash_we_n, flash_oe_n, bus.rsp_valid, bus.rsp_err, busy} !== 6'b111000
        || flash_addr !== 24'h0 || flash_wdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset values: strobes=%b%b%b rsp_valid=%b err=%b busy=%b addr=%h wdata=%h rdata=%h",
               flash_cs_n, flash_we_n, flash_oe_n, bus.rsp_valid, bus.rsp_err, busy,
               flash_addr, flash_wdata, bus.rsp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.req_ready, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset release: req_ready/busy=%b, expected 10", {bus.req_ready, busy});
    end
  endtask

  task automatic test_read_basic();
    model_lat = 0;
    do_access(1'b0, 24'h000123, 32'h0, 0, SETUP + 2 + REC, ref_read(24'h000123), 1'b0,
              "read_basic");
  endtask

  task automatic test_write_basic();
    do_access(1'b1, 24'hFFFFFF, 32'hA5A5A5A5, 0, WR_LAT, 32'h0, 1'b0, "write_basic");
  endtask

  task automatic test_timeout();
    model_en = 1'b0;
    do_access(1'b0, 24'h000200, 32'h0, 1, SETUP + TMO + REC, 32'h0, 1'b1, "read_timeout");
    model_en = 1'b1;
  endtask

  task automatic test_hold();
    bit got = 1'b0;
    bit bad = 1'b0;
    int lat = 0;
    model_lat = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 24'h000123;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      got = bus.rsp_valid;
    end
    // Second request waits while the first response is held.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 24'h000400;
    bus.req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!bus.rsp_valid || bus.rsp_rdata !== ref_read(24'h000123) || bus.rsp_err
          || bus.req_ready || !flash_cs_n || !busy) bad = 1'b1;
    end
    n_checks++;
    if (!got || bad) begin
      n_fail++;
      $display("FAIL hold stable: got_rsp=%b, changed_while_held=%b (expected 1, 0)", got, bad);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready, flash_cs_n} !== 3'b011) begin
      n_fail++;
      $display("FAIL hold handshake: rsp_valid/req_ready/cs_n=%b, expected 011",
               {bus.rsp_valid, bus.req_ready, flash_cs_n});
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if ({flash_cs_n, bus.req_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL hold second accept: cs_n/req_ready=%b, expected 00",
               {flash_cs_n, bus.req_ready});
    end
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    n_checks++;
    if (!got || lat !== WR_LAT) begin
      n_fail++;
      $display("FAIL hold second write: seen=%b latency %0d, expected 1 and %0d", got, lat, WR_LAT);
    end
    ref_mem[24'h000400] = 32'hCAFEF00D;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    model_hold = 3;
    model_lat  = 0;
    do_access(1'b0, 24'h000400, 32'h0, 0, SETUP + 2 + REC, ref_read(24'h000400), 1'b0, "b2b_read1");
    do_access(1'b1, 24'h000401, 32'h13579BDF, 0, WR_LAT, 32'h0, 1'b0, "b2b_write");
    model_lat = 2;
    do_access(1'b0, 24'h000401, 32'h0, 0, SETUP + 4 + REC, ref_read(24'h000401), 1'b0, "b2b_read2");
    model_hold = 0;
    model_lat  = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      bit          we    = 1'($urandom_range(0, 1));
      logic [23:0] addr  = 24'h000100 + 24'($urandom_range(0, 7));
      logic [31:0] wdata = $urandom;
      int          lat   = $urandom_range(0, 4);
      int          dly   = $urandom_range(0, 3);
      model_lat = lat;
      do_access(we, addr, wdata, dly, we ? WR_LAT : SETUP + lat + 2 + REC,
                we ? 32'h0 : ref_read(addr), 1'b0, we ? "rand_write" : "rand_read");
    end
    model_lat = 0;
  endtask

  task automatic test_reset_mid_write();
    bit bad = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 24'h000300;
    bus.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    n_checks++;
    if ({flash_cs_n, flash_we_n} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid precondition: cs_n/we_n=%b, expected 00", {flash_cs_n, flash_we_n});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({flash_cs_n, flash_we_n, flash_oe_n, busy, bus.rsp_valid} !== 5'b11100) begin
      n_fail++;
      $display("FAIL reset_mid async: cs/we/oe/busy/rsp_valid=%b, expected 11100",
               {flash_cs_n, flash_we_n, flash_oe_n, busy, bus.rsp_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || !flash_cs_n) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_mid dropped: response or access seen after reset, expected none");
    end
    do_access(1'b1, 24'h000301, 32'h0BADF00D, 0, WR_LAT, 32'h0, 1'b0, "post_reset_write");
    do_access(1'b0, 24'h000301, 32'h0, 0, SETUP + 2 + REC, ref_read(24'h000301), 1'b0,
              "post_reset_read");
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    fmem[24'h000123]    = 32'hDEADBEEF;
    ref_mem[24'h000123] = 32'hDEADBEEF;

    test_reset();
    test_read_basic();
    test_write_basic();
    test_timeout();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_write();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
